// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with Start/Done/Ack handshake.
// Optional macro MULT_SIGNED_EN adds the Signed port for two's-complement operands.
module seq_multiplier_n #(
  parameter int WIDTH          = 8,
  parameter bit HOLD_UNTIL_ACK = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic [WIDTH-1:0]   Multiplier_Q,
  input  logic [WIDTH-1:0]   Multiplier_R,
`ifdef MULT_SIGNED_EN
  input  logic               Signed,
`endif
  output logic [2*WIDTH-1:0] Multiplier_P,
  output logic               Busy,
  output logic               Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;
  logic             sgn;

  logic             last_step;
  logic             ext_acc;
  logic             ext_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;

`ifdef MULT_SIGNED_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sgn <= 1'b0;
    end else if (state == ST_IDLE && Start) begin
      sgn <= Signed;
    end
  end
`else
  assign sgn = 1'b0;
`endif

  // One shift-add step; the extension bit is the carry when unsigned, the sign when signed.
  // In signed mode the final step weighs Q's MSB negatively, so R is subtracted.
  always_comb begin
    last_step = (cnt == CNT_W'(WIDTH - 1));
    ext_acc   = sgn & acc[WIDTH-1];
    ext_r     = sgn & r_reg[WIDTH-1];
    sum       = {ext_acc, acc};
    if (q_reg[0]) begin
      if (sgn && last_step) begin
        sum = {ext_acc, acc} - {ext_r, r_reg};
      end else begin
        sum = {ext_acc, acc} + {ext_r, r_reg};
      end
    end
    acc_nxt = sum[WIDTH:1];
    q_nxt   = {sum[0], q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      cnt          <= '0;
      Multiplier_P <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            q_reg <= Multiplier_Q;
            r_reg <= Multiplier_R;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc   <= acc_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            Multiplier_P <= {acc_nxt, q_nxt};
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!HOLD_UNTIL_ACK || Ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state == ST_CALC);
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed bench for seq_multiplier_n: WIDTH=8 hold-until-ack instance plus WIDTH=4 pulse instance.
// Signed-mode vectors run only when MULT_SIGNED_EN is defined.
module tb_seq_multiplier_n;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Start2;
  logic        Ack;
  logic [7:0]  q;
  logic [7:0]  r;
  logic [3:0]  q2;
  logic [3:0]  r2;
  logic [15:0] p;
  logic        busy;
  logic        done;
  logic [7:0]  p2;
  logic        busy2;
  logic        done2;
`ifdef MULT_SIGNED_EN
  logic        sgn_in;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  seq_multiplier_n #(.WIDTH(8), .HOLD_UNTIL_ACK(1'b1)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Ack          (Ack),
    .Multiplier_Q (q),
    .Multiplier_R (r),
`ifdef MULT_SIGNED_EN
    .Signed       (sgn_in),
`endif
    .Multiplier_P (p),
    .Busy         (busy),
    .Done         (done)
  );

  seq_multiplier_n #(.WIDTH(4), .HOLD_UNTIL_ACK(1'b0)) dut2 (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start2),
    .Ack          (Ack),
    .Multiplier_Q (q2),
    .Multiplier_R (r2),
`ifdef MULT_SIGNED_EN
    .Signed       (1'b0),
`endif
    .Multiplier_P (p2),
    .Busy         (busy2),
    .Done         (done2)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    q     = a;
    r     = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Full transaction with a bounded wait for Done, then Ack back to IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] res, output bit ok);
    launch(a, b);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    res = p;
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    Start  = 1'b0;
    Start2 = 1'b0;
    Ack    = 1'b0;
    q      = '0;
    r      = '0;
    q2     = '0;
    r2     = '0;
`ifdef MULT_SIGNED_EN
    sgn_in = 1'b0;
`endif
    #2;
    Reset = 1'b0;
    #2;
    checks++;
    if (p !== 16'h0000) begin
      errors++;
      $display("FAIL reset_p: got %h expected 0000", p);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (p2 !== 8'h00 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2: got p=%h busy=%b done=%b expected 00 0 0", p2, busy2, done2);
    end
    tick();
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_full_scale();
    launch(8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL calc_window[%0d]: got busy=%b done=%b expected 1 0", i, busy, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_latency: got busy=%b done=%b expected 0 1", busy, done);
    end
    checks++;
    if (p !== 16'hFE01) begin
      errors++;
      $display("FAIL ff_x_ff: got %h expected fe01", p);
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: got done=%b expected 0", done);
    end
  endtask

  task automatic test_zero_hold();
    launch(8'h00, 8'hA5);
    checks++;
    if (p !== 16'hFE01) begin
      errors++;
      $display("FAIL p_hold_calc: got %h expected fe01", p);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (done !== 1'b1 || p !== 16'h0000) begin
      errors++;
      $display("FAIL zero_result: got done=%b p=%h expected 1 0000", done, p);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || p !== 16'h0000) begin
        errors++;
        $display("FAIL hold_no_ack[%0d]: got done=%b p=%h expected 1 0000", i, done, p);
      end
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== 16'h0000) begin
      errors++;
      $display("FAIL ack_to_idle: got done=%b busy=%b p=%h expected 0 0 0000", done, busy, p);
    end
  endtask

  task automatic test_ignored_start();
    int extra;
    launch(8'h03, 8'h07);
    q     = 8'hFF;
    r     = 8'hFF;
    Start = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (done !== 1'b1 || p !== 16'h0015) begin
      errors++;
      $display("FAIL start_in_calc: got done=%b p=%h expected 1 0015", done, p);
    end
    Ack = 1'b1;
    tick();
    Start = 1'b0;
    Ack   = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_ack: got busy=%b done=%b expected 0 0", busy, done);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy || done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL single_done: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [15:0] res;
    bit          ok;
    launch(8'h12, 8'h34);
    for (int i = 0; i < 3; i++) tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (p !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_calc: got p=%h busy=%b done=%b expected 0000 0 0", p, busy, done);
    end
    tick();
    Reset = 1'b1;
    tick();
    run_op(8'h12, 8'h34, res, ok);
    checks++;
    if (!ok || res !== 16'h03A8) begin
      errors++;
      $display("FAIL restart: got ok=%b p=%h expected 1 03a8", ok, res);
    end
  endtask

  task automatic test_operands();
    logic [15:0] res;
    bit          ok;
    run_op(8'hFD, 8'h05, res, ok);
    checks++;
    if (!ok || res !== 16'h04F1) begin
      errors++;
      $display("FAIL unsigned_fd_05: got ok=%b p=%h expected 1 04f1", ok, res);
    end
    run_op(8'h80, 8'h80, res, ok);
    checks++;
    if (!ok || res !== 16'h4000) begin
      errors++;
      $display("FAIL unsigned_80_80: got ok=%b p=%h expected 1 4000", ok, res);
    end
`ifdef MULT_SIGNED_EN
    sgn_in = 1'b1;
    run_op(8'hFD, 8'h05, res, ok);
    checks++;
    if (!ok || res !== 16'hFFF1) begin
      errors++;
      $display("FAIL signed_fd_05: got ok=%b p=%h expected 1 fff1", ok, res);
    end
    run_op(8'h80, 8'h80, res, ok);
    checks++;
    if (!ok || res !== 16'h4000) begin
      errors++;
      $display("FAIL signed_80_80: got ok=%b p=%h expected 1 4000", ok, res);
    end
    run_op(8'h05, 8'hFD, res, ok);
    checks++;
    if (!ok || res !== 16'hFFF1) begin
      errors++;
      $display("FAIL signed_05_fd: got ok=%b p=%h expected 1 fff1", ok, res);
    end
    sgn_in = 1'b0;
    run_op(8'h80, 8'h80, res, ok);
    checks++;
    if (!ok || res !== 16'h4000) begin
      errors++;
      $display("FAIL signed_off_80_80: got ok=%b p=%h expected 1 4000", ok, res);
    end
`endif
  endtask

  task automatic test_pulse();
    q2     = 4'hF;
    r2     = 4'hF;
    Start2 = 1'b1;
    tick();
    Start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy2 !== 1'b1 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL pulse_calc[%0d]: got busy=%b done=%b expected 1 0", i, busy2, done2);
      end
      tick();
    end
    checks++;
    if (done2 !== 1'b1 || p2 !== 8'hE1) begin
      errors++;
      $display("FAIL pulse_done: got done=%b p=%h expected 1 e1", done2, p2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0 || p2 !== 8'hE1) begin
      errors++;
      $display("FAIL pulse_return: got done=%b busy=%b p=%h expected 0 0 e1", done2, busy2, p2);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_zero_hold();
    test_ignored_start();
    test_reset_mid_calc();
    test_operands();
    test_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
